// File: rtl/jrb8_spi_pkg.sv
// Shared types and constants for the SPI memory controller: op/state encodings,
// default flash command bytes and the 40-bit frame layout.
package jrb8_spi_pkg;

  typedef enum logic [1:0] {
    OP_ROM_READ  = 2'b00,
    OP_RAM_READ  = 2'b01,
    OP_RAM_WRITE = 2'b10,
    OP_RSVD      = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

  localparam logic [7:0] CMD_READ_DFLT  = 8'h03;
  localparam logic [7:0] CMD_WRITE_DFLT = 8'h02;
  localparam int         FRAME_BITS     = 40;

  // Frame: opcode, 8'h00, addr hi, addr lo, data (zero for reads).
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input op_e         op,
    input logic [15:0] addr,
    input logic [7:0]  wdata,
    input logic [7:0]  cmd_read,
    input logic [7:0]  cmd_write
  );
    logic [7:0] cmd;
    logic [7:0] data;
    cmd  = (op == OP_RAM_WRITE) ? cmd_write : cmd_read;
    data = (op == OP_RAM_WRITE) ? wdata : 8'h00;
    return {cmd, 8'h00, addr, data};
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Request/response and SPI pin bundle between the control unit, the controller
// and the external ROM/RAM devices.
interface spi_mem_ctrl_if;
  import jrb8_spi_pkg::*;

  logic        spi_executing;
  op_e         op;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        spi_done;
  logic [7:0]  rdata;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs_rom_n;
  logic        cs_ram_n;

  modport master (
    output spi_executing, op, addr, wdata, miso,
    input  spi_done, rdata, sclk, mosi, cs_rom_n, cs_ram_n
  );

  modport slave (
    input  spi_executing, op, addr, wdata, miso,
    output spi_done, rdata, sclk, mosi, cs_rom_n, cs_ram_n
  );
endinterface

// File: rtl/spi_bit_engine.sv
// 40-bit MSB-first mode-0 shifter: two clk cycles per bit, sclk high in phase 1,
// miso captured at the end of phase 1 for the final data byte only.
module spi_bit_engine
  import jrb8_spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  last,
  output logic [7:0]            rx
);

  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);
  localparam logic [5:0] RX_FIRST = 6'(FRAME_BITS - 8);

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [5:0]            bit_q, bit_d;
  logic                  phase_q, phase_d;
  logic                  busy_q, busy_d;
  logic [7:0]            rx_q, rx_d;

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sr_d    = sr_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    rx_d    = rx_q;
    if (load) begin
      sr_d    = frame;
      bit_d   = '0;
      phase_d = 1'b0;
      busy_d  = 1'b1;
      rx_d    = '0;
    end else if (busy_q) begin
      if (!phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (bit_q >= RX_FIRST) rx_d = {rx_q[6:0], miso};
        if (bit_q == LAST_BIT) begin
          busy_d = 1'b0;
          bit_d  = '0;
          sr_d   = '0;
        end else begin
          bit_d = bit_q + 6'd1;
          sr_d  = {sr_q[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
      rx_q    <= '0;
    end else begin
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      rx_q    <= rx_d;
    end
  end

  assign sclk = busy_q & phase_q;
  assign mosi = sr_q[FRAME_BITS-1];
  assign last = busy_q & phase_q & (bit_q == LAST_BIT);
  assign rx   = rx_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI memory controller top: accepts one CU request per idle period, runs a
// 40-bit frame to ROM or RAM, and signals completion with a clean spi_done edge.
module spi_mem_ctrl
  import jrb8_spi_pkg::*;
#(
  parameter logic [7:0] CMD_READ  = CMD_READ_DFLT,
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DFLT
) (
  input  logic         clk,
  input  logic         rst,
  spi_mem_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [7:0] rdata_q, rdata_d;
  logic       spi_done_q, spi_done_d;
  logic       load;
  logic       eng_last;
  logic [7:0] eng_rx;
  logic       accept;

  // spi_done_q gates acceptance, so the IDLE re-entry cycle never accepts.
  assign accept = (state_q == ST_IDLE) && spi_done_q && bus.spi_executing;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rdata_d    = rdata_q;
    spi_done_d = (state_q == ST_IDLE);
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          spi_done_d = 1'b0;
          if (bus.op != OP_RSVD) begin
            op_d    = bus.op;
            load    = 1'b1;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (eng_last) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        if (op_q != OP_RAM_WRITE) rdata_d = eng_rx;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ROM_READ;
      rdata_q    <= 8'h00;
      spi_done_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rdata_q    <= rdata_d;
      spi_done_q <= spi_done_d;
    end
  end

  spi_bit_engine u_engine (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .frame (build_frame(bus.op, bus.addr, bus.wdata, CMD_READ, CMD_WRITE)),
    .miso  (bus.miso),
    .sclk  (bus.sclk),
    .mosi  (bus.mosi),
    .last  (eng_last),
    .rx    (eng_rx)
  );

  assign bus.cs_rom_n = !((state_q == ST_SHIFT) && (op_q == OP_ROM_READ));
  assign bus.cs_ram_n = !((state_q == ST_SHIFT) &&
                          ((op_q == OP_RAM_READ) || (op_q == OP_RAM_WRITE)));
  assign bus.spi_done = spi_done_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: a simple SPI device model captures the mosi
// frame and returns a programmed byte on miso during the data phase.
module tb_spi_mem_ctrl;
  import jrb8_spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_mem_ctrl_if bus ();

  spi_mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Device model: frame capture and miso response, restarted on every CS fall.
  logic [39:0] tx_frame  = '0;
  int          bit_idx   = 0;
  int          sclk_tot  = 0;
  logic [7:0]  miso_byte = 8'h00;
  logic        miso_v    = 1'b0;
  wire         cs_any    = bus.cs_rom_n & bus.cs_ram_n;
  assign bus.miso = miso_v;

  always @(posedge bus.sclk or negedge cs_any) begin
    if (bus.sclk) begin
      tx_frame = {tx_frame[38:0], bus.mosi};
      if (bit_idx >= 32 && bit_idx <= 39) miso_v = miso_byte[39 - bit_idx];
      bit_idx  = bit_idx + 1;
      sclk_tot = sclk_tot + 1;
    end else begin
      tx_frame = '0;
      bit_idx  = 0;
      miso_v   = 1'b0;
    end
  end

  int rom_low_cnt  = 0;
  int ram_low_cnt  = 0;
  int both_low_cnt = 0;
  always @(negedge clk) begin
    if (!bus.cs_rom_n) rom_low_cnt = rom_low_cnt + 1;
    if (!bus.cs_ram_n) ram_low_cnt = ram_low_cnt + 1;
    if (!bus.cs_rom_n && !bus.cs_ram_n) both_low_cnt = both_low_cnt + 1;
  end

  task automatic start_txn(input op_e op, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic hold);
    @(negedge clk);
    bus.op            = op;
    bus.addr          = addr;
    bus.wdata         = wdata;
    bus.spi_executing = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.spi_executing = 1'b0;
  endtask

  // Counts edges since the accepting edge until spi_done reads high; bounded.
  task automatic wait_done(input int start, output int n);
    n = start;
    while (n < 300) begin
      @(posedge clk);
      n = n + 1;
      #1;
      if (bus.spi_done) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.spi_done !== 1'b1) begin errors++; $display("FAIL reset_done: got %b want 1", bus.spi_done); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
    checks++; if ({bus.sclk, bus.mosi} !== 2'b00) begin errors++; $display("FAIL reset_pins: sclk,mosi got %b want 00", {bus.sclk, bus.mosi}); end
    checks++; if ({bus.cs_rom_n, bus.cs_ram_n} !== 2'b11) begin errors++; $display("FAIL reset_cs: got %b want 11", {bus.cs_rom_n, bus.cs_ram_n}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rom_read();
    int n, rom0, ram0;
    miso_byte = 8'hA5;
    rom0 = rom_low_cnt; ram0 = ram_low_cnt;
    start_txn(OP_ROM_READ, 16'h1234, 8'h77, 1'b0);
    checks++; if (bus.spi_done !== 1'b0) begin errors++; $display("FAIL rom_accept_done: got %b want 0", bus.spi_done); end
    wait_done(0, n);
    checks++; if (n != 82) begin errors++; $display("FAIL rom_latency: got %0d want 82", n); end
    checks++; if (tx_frame !== 40'h0300123400) begin errors++; $display("FAIL rom_frame: got %h want 0300123400", tx_frame); end
    checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL rom_rdata: got %h want a5", bus.rdata); end
    checks++; if (rom_low_cnt - rom0 != 80) begin errors++; $display("FAIL rom_cs_cycles: got %0d want 80", rom_low_cnt - rom0); end
    checks++; if (ram_low_cnt - ram0 != 0) begin errors++; $display("FAIL rom_ram_cs: got %0d want 0", ram_low_cnt - ram0); end
  endtask

  task automatic test_ram_write();
    int n, rom0, ram0;
    miso_byte = 8'h3C;
    rom0 = rom_low_cnt; ram0 = ram_low_cnt;
    start_txn(OP_RAM_WRITE, 16'h00FF, 8'h5A, 1'b0);
    wait_done(0, n);
    checks++; if (n != 82) begin errors++; $display("FAIL wr_latency: got %0d want 82", n); end
    checks++; if (tx_frame !== 40'h020000FF5A) begin errors++; $display("FAIL wr_frame: got %h want 020000ff5a", tx_frame); end
    checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL wr_rdata_kept: got %h want a5", bus.rdata); end
    checks++; if (ram_low_cnt - ram0 != 80) begin errors++; $display("FAIL wr_cs_cycles: got %0d want 80", ram_low_cnt - ram0); end
    checks++; if (rom_low_cnt - rom0 != 0) begin errors++; $display("FAIL wr_rom_cs: got %0d want 0", rom_low_cnt - rom0); end
  endtask

  task automatic test_op_reserved();
    int s0, rom0, ram0;
    s0 = sclk_tot; rom0 = rom_low_cnt; ram0 = ram_low_cnt;
    start_txn(OP_RSVD, 16'hFFFF, 8'hFF, 1'b0);
    checks++; if (bus.spi_done !== 1'b0) begin errors++; $display("FAIL rsvd_done_low: got %b want 0", bus.spi_done); end
    @(posedge clk); #1;
    checks++; if (bus.spi_done !== 1'b1) begin errors++; $display("FAIL rsvd_done_back: got %b want 1", bus.spi_done); end
    repeat (4) @(posedge clk); #1;
    checks++; if (sclk_tot - s0 != 0) begin errors++; $display("FAIL rsvd_sclk: got %0d toggles want 0", sclk_tot - s0); end
    checks++; if ((rom_low_cnt - rom0) + (ram_low_cnt - ram0) != 0) begin errors++; $display("FAIL rsvd_cs: got %0d low cycles want 0", (rom_low_cnt - rom0) + (ram_low_cnt - ram0)); end
    checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL rsvd_rdata: got %h want a5", bus.rdata); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    miso_byte = 8'h81;
    start_txn(OP_RAM_READ, 16'h4321, 8'h00, 1'b0);
    repeat (39) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.spi_done !== 1'b1) begin errors++; $display("FAIL mid_rst_done: got %b want 1", bus.spi_done); end
    checks++; if ({bus.cs_rom_n, bus.cs_ram_n} !== 2'b11) begin errors++; $display("FAIL mid_rst_cs: got %b want 11", {bus.cs_rom_n, bus.cs_ram_n}); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL mid_rst_rdata: got %h want 00", bus.rdata); end
    checks++; if ({bus.sclk, bus.mosi} !== 2'b00) begin errors++; $display("FAIL mid_rst_pins: got %b want 00", {bus.sclk, bus.mosi}); end
    rst = 1'b0;
    start_txn(OP_ROM_READ, 16'hBEEF, 8'h00, 1'b0);
    wait_done(0, n);
    checks++; if (n != 82) begin errors++; $display("FAIL post_rst_latency: got %0d want 82", n); end
    checks++; if (tx_frame !== 40'h0300BEEF00) begin errors++; $display("FAIL post_rst_frame: got %h want 0300beef00", tx_frame); end
    checks++; if (bus.rdata !== 8'h81) begin errors++; $display("FAIL post_rst_rdata: got %h want 81", bus.rdata); end
  endtask

  task automatic test_back_to_back();
    int n, m, ram0;
    logic saw_low;
    miso_byte = 8'h96;
    ram0 = ram_low_cnt;
    start_txn(OP_RAM_READ, 16'h0A0B, 8'h00, 1'b1);
    wait_done(0, n);
    checks++; if (n != 82) begin errors++; $display("FAIL b2b_first_latency: got %0d want 82", n); end
    checks++; if (bus.cs_ram_n !== 1'b1) begin errors++; $display("FAIL b2b_gap_cs: got %b want 1", bus.cs_ram_n); end
    checks++; if (bus.rdata !== 8'h96) begin errors++; $display("FAIL b2b_rdata1: got %h want 96", bus.rdata); end
    m = 0; saw_low = 1'b0;
    while (m < 300) begin
      @(posedge clk);
      m = m + 1;
      #1;
      if (!bus.spi_done) saw_low = 1'b1;
      else if (saw_low) break;
    end
    bus.spi_executing = 1'b0;
    checks++; if (m != 83) begin errors++; $display("FAIL b2b_period: got %0d want 83", m); end
    checks++; if (tx_frame !== 40'h03000A0B00) begin errors++; $display("FAIL b2b_frame2: got %h want 03000a0b00", tx_frame); end
    checks++; if (ram_low_cnt - ram0 != 160) begin errors++; $display("FAIL b2b_cs_cycles: got %0d want 160", ram_low_cnt - ram0); end
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.spi_done !== 1'b1) begin errors++; $display("FAIL b2b_stop: got %b want 1", bus.spi_done); end
  endtask

  task automatic test_mid_frame_change();
    int n, rom0, ram0;
    miso_byte = 8'hE7;
    rom0 = rom_low_cnt; ram0 = ram_low_cnt;
    start_txn(OP_RAM_WRITE, 16'h1357, 8'hC4, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    bus.op = OP_ROM_READ; bus.addr = 16'hFFFF; bus.wdata = 8'h00;
    bus.spi_executing = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.spi_executing = 1'b0;
    wait_done(24, n);
    checks++; if (n != 82) begin errors++; $display("FAIL chg_latency: got %0d want 82", n); end
    checks++; if (tx_frame !== 40'h02001357C4) begin errors++; $display("FAIL chg_frame: got %h want 02001357c4", tx_frame); end
    checks++; if (ram_low_cnt - ram0 != 80 || rom_low_cnt - rom0 != 0) begin errors++; $display("FAIL chg_cs: got ram %0d rom %0d want 80 0", ram_low_cnt - ram0, rom_low_cnt - rom0); end
    checks++; if (bus.rdata !== 8'h96) begin errors++; $display("FAIL chg_rdata: got %h want 96", bus.rdata); end
    checks++; if (both_low_cnt != 0) begin errors++; $display("FAIL cs_exclusive: got %0d both-low cycles want 0", both_low_cnt); end
  endtask

  initial begin
    bus.spi_executing = 1'b0;
    bus.op            = OP_ROM_READ;
    bus.addr          = 16'h0000;
    bus.wdata         = 8'h00;
    test_reset();
    test_rom_read();
    test_ram_write();
    test_op_reserved();
    test_reset_mid_frame();
    test_back_to_back();
    test_mid_frame_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
